// File: rtl/inst_dec_pkg.sv
// Shared opcode map, field positions and write-enable rule for the instruction decoder.
// Consumed by inst_dec; INST_DEC_ILLEGAL_EN users also rely on is_rsv().
package inst_dec_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_OR     = 4'h2;
  localparam logic [3:0] OP_XOR    = 4'h3;
  localparam logic [3:0] OP_AND    = 4'h4;
  localparam logic [3:0] OP_NOT    = 4'h5;
  localparam logic [3:0] OP_READ   = 4'h6;
  localparam logic [3:0] OP_WRITE  = 4'h7;
  localparam logic [3:0] OP_LOAD   = 4'h8;
  localparam logic [3:0] OP_CMP    = 4'h9;
  localparam logic [3:0] OP_SHL    = 4'hA;
  localparam logic [3:0] OP_SHR    = 4'hB;
  localparam logic [3:0] OP_JUMP   = 4'hC;
  localparam logic [3:0] OP_JUMPEQ = 4'hD;
  localparam logic [3:0] OP_RSV_E  = 4'hE;
  localparam logic [3:0] OP_RSV_F  = 4'hF;

  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int RD_HI   = 11;
  localparam int RD_LO   = 9;
  localparam int FLAG_B  = 8;
  localparam int RA_HI   = 7;
  localparam int RA_LO   = 5;
  localparam int RB_HI   = 4;
  localparam int RB_LO   = 2;
  localparam int IMM8_HI = 7;
  localparam int IMM8_LO = 0;

  // Stores and branches are the only instructions that leave the register file alone.
  function automatic logic regwe_of(input logic [3:0] opcode);
    logic we;
    case (opcode)
      OP_WRITE, OP_JUMP, OP_JUMPEQ:                  we = 1'b0;
      OP_ADD, OP_SUB, OP_OR, OP_XOR, OP_AND, OP_NOT: we = 1'b1;
      OP_READ, OP_LOAD, OP_CMP, OP_SHL, OP_SHR:      we = 1'b1;
      OP_RSV_E, OP_RSV_F:                            we = 1'b1;
      default:                                       we = 1'b1;
    endcase
    return we;
  endfunction

  function automatic logic is_rsv(input logic [3:0] opcode);
    return (opcode == OP_RSV_E) || (opcode == OP_RSV_F);
  endfunction

endpackage

// File: rtl/inst_dec.sv
// Registered 16-bit instruction decoder: field split, byte-duplicated immediate, regfile write enable.
// Optional INST_DEC_ILLEGAL_EN adds O_Illegal and suppresses O_Regwe for reserved opcodes.
module inst_dec
  import inst_dec_pkg::*;
#(
  parameter int INST_W = 16,
  parameter int SEL_W  = 3
) (
  input  logic              I_Clk,
  input  logic              I_Rst,
  input  logic              I_En,
  input  logic [INST_W-1:0] I_Inst,
  output logic [4:0]        O_Aluop,
  output logic [SEL_W-1:0]  O_SelA,
  output logic [SEL_W-1:0]  O_SelB,
  output logic [SEL_W-1:0]  O_SelD,
  output logic [INST_W-1:0] O_Imm,
`ifdef INST_DEC_ILLEGAL_EN
  output logic              O_Illegal,
`endif
  output logic              O_Regwe
);

  logic [3:0]        opcode;
  logic              flag;
  logic [7:0]        imm8;
  logic              regwe_nxt;

  assign opcode = I_Inst[OPC_HI:OPC_LO];
  assign flag   = I_Inst[FLAG_B];
  assign imm8   = I_Inst[IMM8_HI:IMM8_LO];

`ifdef INST_DEC_ILLEGAL_EN
  assign regwe_nxt = regwe_of(opcode) & ~is_rsv(opcode);
`else
  assign regwe_nxt = regwe_of(opcode);
`endif

  always_ff @(posedge I_Clk or posedge I_Rst) begin
    if (I_Rst) begin
      O_Aluop   <= '0;
      O_SelA    <= '0;
      O_SelB    <= '0;
      O_SelD    <= '0;
      O_Imm     <= '0;
      O_Regwe   <= 1'b0;
`ifdef INST_DEC_ILLEGAL_EN
      O_Illegal <= 1'b0;
`endif
    end else if (I_En) begin
      O_Aluop   <= {opcode, flag};
      O_SelD    <= I_Inst[RD_HI:RD_LO];
      O_SelA    <= I_Inst[RA_HI:RA_LO];
      O_SelB    <= I_Inst[RB_HI:RB_LO];
      // Both halves carry the byte; the consumer selects one using flag.
      O_Imm     <= {imm8, imm8};
      O_Regwe   <= regwe_nxt;
`ifdef INST_DEC_ILLEGAL_EN
      O_Illegal <= is_rsv(opcode);
`endif
    end
  end

endmodule

// File: tb/tb_inst_dec.sv
// Self-checking bench for inst_dec: vector table through a scoreboard queue plus
// hand-written reset sequences. Build with +define+INST_DEC_ILLEGAL_EN to cover the option.
module tb_inst_dec;

  logic        I_Clk = 1'b0;
  logic        I_Rst;
  logic        I_En;
  logic [15:0] I_Inst;
  logic [4:0]  O_Aluop;
  logic [2:0]  O_SelA, O_SelB, O_SelD;
  logic [15:0] O_Imm;
  logic        O_Regwe;
  logic        O_Illegal;

  int n_tests = 0;
  int n_fail  = 0;

  inst_dec dut (
    .I_Clk    (I_Clk),
    .I_Rst    (I_Rst),
    .I_En     (I_En),
    .I_Inst   (I_Inst),
    .O_Aluop  (O_Aluop),
    .O_SelA   (O_SelA),
    .O_SelB   (O_SelB),
    .O_SelD   (O_SelD),
    .O_Imm    (O_Imm),
`ifdef INST_DEC_ILLEGAL_EN
    .O_Illegal(O_Illegal),
`endif
    .O_Regwe  (O_Regwe)
  );

`ifndef INST_DEC_ILLEGAL_EN
  assign O_Illegal = 1'b0;
`endif

  always #5 I_Clk = ~I_Clk;

  typedef struct {
    logic [4:0]  aluop;
    logic [2:0]  sel_d;
    logic [2:0]  sel_a;
    logic [2:0]  sel_b;
    logic [15:0] imm;
    logic        regwe;
    logic        ill;
  } exp_t;

  typedef struct {
    logic        en;
    logic [15:0] inst;
    exp_t        exp;
  } vec_t;

  vec_t vecs[15];
  exp_t sb_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check_outs(input string tag, input exp_t e);
    check({tag, ".aluop"}, {11'd0, O_Aluop}, {11'd0, e.aluop});
    check({tag, ".sel_d"}, {13'd0, O_SelD},  {13'd0, e.sel_d});
    check({tag, ".sel_a"}, {13'd0, O_SelA},  {13'd0, e.sel_a});
    check({tag, ".sel_b"}, {13'd0, O_SelB},  {13'd0, e.sel_b});
    check({tag, ".imm"},   O_Imm,            e.imm);
    check({tag, ".regwe"}, {15'd0, O_Regwe}, {15'd0, e.regwe});
`ifdef INST_DEC_ILLEGAL_EN
    check({tag, ".illegal"}, {15'd0, O_Illegal}, {15'd0, e.ill});
`endif
  endtask

  function automatic exp_t mk(input logic [4:0] a, input logic [2:0] d, input logic [2:0] sa,
                              input logic [2:0] sb, input logic [15:0] imm, input logic we,
                              input logic ill);
    exp_t e;
    e.aluop = a; e.sel_d = d; e.sel_a = sa; e.sel_b = sb;
    e.imm = imm; e.regwe = we; e.ill = ill;
    return e;
  endfunction

  task automatic tick();
    @(posedge I_Clk);
    #1;
  endtask

  localparam logic RSV_WE = `ifdef INST_DEC_ILLEGAL_EN 1'b0 `else 1'b1 `endif ;

  exp_t zero_e, e_1700, got_e;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    zero_e = mk(5'b0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b0);
    // {en, inst, {aluop, rD, rA, rB, imm, regwe, illegal}}
    vecs[0]  = '{1'b0, 16'h1704, mk(5'b00000, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b0)};
    vecs[1]  = '{1'b0, 16'h1704, mk(5'b00000, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b0)};
    vecs[2]  = '{1'b1, 16'h1704, mk(5'b00011, 3'd3, 3'd0, 3'd1, 16'h0404, 1'b1, 1'b0)};
    vecs[3]  = '{1'b1, 16'h7E5C, mk(5'b01110, 3'd7, 3'd2, 3'd7, 16'h5C5C, 1'b0, 1'b0)};
    vecs[4]  = '{1'b1, 16'hC000, mk(5'b11000, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b0)};
    vecs[5]  = '{1'b1, 16'hD000, mk(5'b11010, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b0)};
    vecs[6]  = '{1'b1, 16'h8AFF, mk(5'b10000, 3'd5, 3'd7, 3'd7, 16'hFFFF, 1'b1, 1'b0)};
    vecs[7]  = '{1'b1, 16'h2BE4, mk(5'b00101, 3'd5, 3'd7, 3'd1, 16'hE4E4, 1'b1, 1'b0)};
    vecs[8]  = '{1'b0, 16'h0000, mk(5'b00101, 3'd5, 3'd7, 3'd1, 16'hE4E4, 1'b1, 1'b0)};
    vecs[9]  = '{1'b0, 16'h0000, mk(5'b00101, 3'd5, 3'd7, 3'd1, 16'hE4E4, 1'b1, 1'b0)};
    vecs[10] = '{1'b0, 16'h0000, mk(5'b00101, 3'd5, 3'd7, 3'd1, 16'hE4E4, 1'b1, 1'b0)};
    vecs[11] = '{1'b1, 16'hF000, mk(5'b11110, 3'd0, 3'd0, 3'd0, 16'h0000, RSV_WE, 1'b1)};
    vecs[12] = '{1'b1, 16'hE1A8, mk(5'b11101, 3'd0, 3'd5, 3'd2, 16'hA8A8, RSV_WE, 1'b1)};
    vecs[13] = '{1'b1, 16'h5F13, mk(5'b01011, 3'd7, 3'd0, 3'd4, 16'h1313, 1'b1, 1'b0)};
    vecs[14] = '{1'b1, 16'h0000, mk(5'b00000, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b1, 1'b0)};

    // Reset takes effect with no clock edge, even with enable high.
    I_Rst = 1'b0; I_En = 1'b1; I_Inst = 16'hFFFF;
    #1 I_Rst = 1'b1;
    #1 check_outs("rst_async", zero_e);
    tick();
    check_outs("rst_prio", zero_e);

    @(negedge I_Clk);
    I_Rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      I_En = vecs[i].en;
      I_Inst = vecs[i].inst;
      sb_q.push_back(vecs[i].exp);
      tick();
      if (sb_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_empty: got 0 entries expected 1");
      end else begin
        got_e = sb_q.pop_front();
        check_outs($sformatf("vec%0d", i), got_e);
      end
      @(negedge I_Clk);
    end

    // Mid-stream reset pulse between edges, then redecode on the first edge after release.
    e_1700 = mk(5'b00011, 3'd3, 3'd0, 3'd0, 16'h0000, 1'b1, 1'b0);
    I_En = 1'b1; I_Inst = 16'h1700;
    tick();
    check_outs("pre_pulse", e_1700);
    @(negedge I_Clk);
    I_Rst = 1'b1;
    #1 check_outs("mid_rst", zero_e);
    #1 I_Rst = 1'b0;
    #1 check_outs("post_rel_hold", zero_e);
    tick();
    check_outs("redecode", e_1700);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
